// File: rtl/lampfpu_sqrt_iter_if.sv
// lampfpu_sqrt_iter_if: operand/result bus of the iterative square-root unit.
//   Operand side : valid_i/ready_o handshake, sign, extended exponent,
//                  mantissa with explicit hidden bit, leading-zero count, class flags.
//   Result side  : valid_o/ready_i handshake, sign, biased exponent,
//                  extended mantissa {hidden, fraction, 3 guard, sticky},
//                  isToRound_o, isInvalid_o.
//   master : the surrounding FPU (drives operands, consumes results).
//   slave  : the sqrt unit.
interface lampfpu_sqrt_iter_if #(
    parameter int E_DW = 8,
    parameter int F_DW = 7
);
    localparam int NLZ_W = $clog2(F_DW+1);

    logic              valid_i;
    logic              ready_o;
    logic              s_i;
    logic [E_DW:0]     extE_i;
    logic [F_DW:0]     extF_i;
    logic [NLZ_W-1:0]  nlz_i;
    logic              isZ_i;
    logic              isInf_i;
    logic              isSNAN_i;
    logic              isQNAN_i;

    logic              valid_o;
    logic              ready_i;
    logic              s_res_o;
    logic [E_DW-1:0]   e_res_o;
    logic [F_DW+4:0]   f_res_o;
    logic              isToRound_o;
    logic              isInvalid_o;

    modport master (
        output valid_i, s_i, extE_i, extF_i, nlz_i, isZ_i, isInf_i, isSNAN_i, isQNAN_i, ready_i,
        input  ready_o, valid_o, s_res_o, e_res_o, f_res_o, isToRound_o, isInvalid_o
    );

    modport slave (
        input  valid_i, s_i, extE_i, extF_i, nlz_i, isZ_i, isInf_i, isSNAN_i, isQNAN_i, ready_i,
        output ready_o, valid_o, s_res_o, e_res_o, f_res_o, isToRound_o, isInvalid_o
    );
endinterface

// File: rtl/lampfpu_sqrt_iter.sv
// lampfpu_sqrt_iter: iterative square root, one root bit per cycle
// (restoring digit recurrence), for the lampFPU datapath.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lampfpu_sqrt_iter_if.slave (operand and result handshakes)
//   flush_i  : only with LAMP_SQRT_FLUSH_EN defined; aborts any operation
//              and returns to IDLE on the next edge.
// Latency from the accept edge: ITER+1 edges (normal), 2 edges (special),
// counting the accept edge itself.
module lampfpu_sqrt_iter #(
    parameter int E_DW   = 8,
    parameter int F_DW   = 7,
    parameter int E_BIAS = 2**(E_DW-1)-1
) (
    input  logic clk,
    input  logic rst,
`ifdef LAMP_SQRT_FLUSH_EN
    input  logic flush_i,
`endif
    lampfpu_sqrt_iter_if.slave bus
);
    localparam int ITER   = F_DW+5;
    localparam int ROOT_W = F_DW+4;
    localparam int REM_W  = F_DW+7;
    localparam int RAD_W  = 2*ROOT_W;
    localparam int CNT_W  = $clog2(ITER);
    localparam int EX_W   = E_DW+2;

    typedef enum logic [1:0] {IDLE, SPEC, CALC, DONE} state_t;
    state_t state, state_nx;

    logic              accept, special_in;
    logic              s_q, z_q, inf_q, snan_q, nan_q;
    logic [RAD_W-1:0]  rad_q;
    logic [REM_W-1:0]  rem_q;
    logic [ROOT_W-1:0] root_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [E_DW-1:0]   e_calc_q;

    logic              res_s, res_round, res_inv;
    logic [E_DW-1:0]   res_e;
    logic [F_DW+4:0]   res_f;

    // operand pre-computation, consumed on the accept edge
    logic [F_DW:0]        m;
    logic signed [EX_W-1:0] e_unb, e_half;
    logic [F_DW+1:0]      rad_top;
    logic [E_DW-1:0]      e_res_in;

    // one recurrence step
    logic [REM_W-1:0]  rem_sh;
    logic [REM_W:0]    diff;
    logic              bit_ok;

    assign accept     = bus.valid_i & (state == IDLE);
    assign special_in = bus.isZ_i | bus.isInf_i | bus.isSNAN_i | bus.isQNAN_i | bus.s_i;

    assign m        = bus.extF_i << bus.nlz_i;
    assign e_unb    = EX_W'({1'b0, bus.extE_i}) - EX_W'(E_BIAS) - EX_W'(bus.nlz_i);
    assign e_half   = e_unb >>> 1;
    assign e_res_in = E_DW'(e_half + EX_W'(E_BIAS));
    // odd exponent: fold one factor of 2 into the radicand, giving [2,4)
    assign rad_top  = e_unb[0] ? {m, 1'b0} : {1'b0, m};

    assign rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    assign diff   = {1'b0, rem_sh} - (REM_W+1)'({root_q, 2'b01});
    assign bit_ok = ~diff[REM_W];

    assign bus.ready_o     = (state == IDLE);
    assign bus.valid_o     = (state == DONE);
    assign bus.s_res_o     = res_s;
    assign bus.e_res_o     = res_e;
    assign bus.f_res_o     = res_f;
    assign bus.isToRound_o = res_round;
    assign bus.isInvalid_o = res_inv;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = special_in ? SPEC : CALC;
            SPEC: state_nx = DONE;
            CALC: if (cnt_q == CNT_W'(ITER-1)) state_nx = DONE;
            DONE: if (bus.ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
`ifdef LAMP_SQRT_FLUSH_EN
        if (flush_i) state_nx = IDLE;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= 1'b0;
            z_q       <= 1'b0;
            inf_q     <= 1'b0;
            snan_q    <= 1'b0;
            nan_q     <= 1'b0;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            cnt_q     <= '0;
            e_calc_q  <= '0;
            res_s     <= 1'b0;
            res_e     <= '0;
            res_f     <= '0;
            res_round <= 1'b0;
            res_inv   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    s_q      <= bus.s_i;
                    z_q      <= bus.isZ_i;
                    inf_q    <= bus.isInf_i;
                    snan_q   <= bus.isSNAN_i;
                    nan_q    <= bus.isSNAN_i | bus.isQNAN_i;
                    rad_q    <= {rad_top, (RAD_W-F_DW-2)'(0)};
                    rem_q    <= '0;
                    root_q   <= '0;
                    cnt_q    <= '0;
                    e_calc_q <= e_res_in;
                end
                SPEC: begin
                    res_round <= 1'b0;
                    res_f     <= '0;
                    res_inv   <= 1'b0;
                    if (nan_q) begin
                        res_s             <= 1'b0;
                        res_e             <= '1;
                        res_f[F_DW+3]     <= 1'b1;
                        res_inv           <= snan_q;
                    end else if (z_q) begin
                        res_s <= s_q;
                        res_e <= '0;
                    end else if (s_q) begin
                        // -Inf or negative nonzero finite
                        res_s         <= 1'b0;
                        res_e         <= '1;
                        res_f[F_DW+3] <= 1'b1;
                        res_inv       <= 1'b1;
                    end else begin
                        res_s <= 1'b0;
                        res_e <= '1;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q < CNT_W'(ROOT_W)) begin
                        rad_q  <= rad_q << 2;
                        root_q <= {root_q[ROOT_W-2:0], bit_ok};
                        rem_q  <= bit_ok ? diff[REM_W-1:0] : rem_sh;
                    end else begin
                        // root already in [1,2): no post-normalisation
                        res_s     <= s_q;
                        res_e     <= e_calc_q;
                        res_f     <= {root_q, |rem_q};
                        res_round <= 1'b1;
                        res_inv   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // inf_q is implied by the class priority (non-NaN, non-zero, positive)
    logic unused_ok;
    assign unused_ok = inf_q;
endmodule
